// File: rtl/mem_bus_bridge_if.sv
// Core-side and memory-side handshake bundles for mem_bus_bridge.
// The core is master of mem_core_if; the bridge is master of mem_bus_if.

interface mem_core_if;
  logic        req;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  write_enable;
  logic [31:0] read_data;
  logic        stall;

  modport master (output req, address, write_data, write_enable,
                  input  read_data, stall);
  modport slave  (input  req, address, write_data, write_enable,
                  output read_data, stall);
endinterface

interface mem_bus_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        we;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (output req_valid, addr, wdata, wstrb, we,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_error);
  modport slave  (input  req_valid, addr, wdata, wstrb, we,
                  output req_ready, rsp_valid, rsp_rdata, rsp_error);
endinterface

// File: rtl/mem_bus_bridge.sv
// Bridges a stalling single-access core memory port onto a valid/ready
// request bus with a pulsed response, a response timeout and error capture.

module mem_bus_bridge #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_READ_DATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  mem_core_if.slave   core,
  mem_bus_if.master   bus,
  output logic        err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  // Last counter value before the access is declared timed out.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic        req_valid_q;
  logic [15:0] cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] err_addr_q;
  logic        is_write;

  assign is_write       = |strb_q;
  assign bus.req_valid  = req_valid_q;
  assign bus.addr       = {addr_q[31:2], 2'b00};
  assign bus.wdata      = wdata_q;
  assign bus.wstrb      = strb_q;
  assign bus.we         = is_write;
  assign core.read_data = rdata_q;
  assign err            = err_q;
  assign err_addr       = err_addr_q;

  // Stall must rise in the very cycle a request arrives in IDLE, so it is combinational.
  always_comb begin
    core.stall = 1'b0;
    case (state_q)
      IDLE:     core.stall = core.req;
      REQ:      core.stall = 1'b1;
      WAIT_RSP: core.stall = 1'b1;
      DONE:     core.stall = 1'b0;
      default:  core.stall = 1'b0;
    endcase
  end

  // Access sequencer: latch request, hand it to the bus, await response or timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      req_valid_q <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (core.req) begin
            addr_q      <= core.address;
            wdata_q     <= core.write_data;
            strb_q      <= core.write_enable;
            req_valid_q <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (bus.req_ready) begin
            req_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (bus.rsp_valid) begin
            if (bus.rsp_error) begin
              if (!is_write) rdata_q <= ERR_READ_DATA;
              err_q      <= 1'b1;
              err_addr_q <= addr_q;
            end else if (!is_write) begin
              rdata_q <= bus.rsp_rdata;
            end
            state_q <= DONE;
          end else if (cnt_q == TimeoutLast) begin
            if (!is_write) rdata_q <= ERR_READ_DATA;
            err_q      <= 1'b1;
            err_addr_q <= addr_q;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Scoreboard bench for mem_bus_bridge: each access pushes its expected
// completion, which is popped and compared in the DONE cycle.

module tb_mem_bus_bridge;

  localparam int          TbTimeout = 4;
  localparam logic [31:0] ErrData   = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] errAddr;
  } expT;

  logic clk;
  logic reset;
  logic err;
  logic [31:0] errAddr;

  mem_core_if coreIf ();
  mem_bus_if  busIf ();

  expT expQ[$];
  logic [31:0] modelRdata;
  logic [31:0] modelErrAddr;
  int checkCount;
  int errorCount;

  mem_bus_bridge #(
    .TIMEOUT_CYCLES(TbTimeout),
    .ERR_READ_DATA (ErrData)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .core    (coreIf),
    .bus     (busIf),
    .err     (err),
    .err_addr(errAddr)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it when observed differs from required.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", tag, actual, expected);
    end
  endtask

  // Runs one full access; rspDelay < 0 means the memory never answers.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int readyDelay,
                               input int rspDelay, input logic [31:0] rspData,
                               input logic rspErr, input logic strayRsp,
                               input logic holdReq);
    expT e;
    logic fail;
    logic [31:0] busAddr;
    int lastWait;
    fail = rspErr || (rspDelay < 0);
    if (strb == 4'b0000) modelRdata = fail ? ErrData : rspData;
    if (fail) modelErrAddr = addr;
    e.rdata   = modelRdata;
    e.err     = fail;
    e.errAddr = modelErrAddr;
    expQ.push_back(e);
    busAddr  = {addr[31:2], 2'b00};
    lastWait = (rspDelay < 0) ? TbTimeout - 1 : rspDelay;

    @(posedge clk); #1;
    coreIf.req          = 1'b1;
    coreIf.address      = addr;
    coreIf.write_data   = wdata;
    coreIf.write_enable = strb;
    @(negedge clk);
    checkOutput("idleStall", 32'(coreIf.stall), 32'd1);
    checkOutput("idleValid", 32'(busIf.req_valid), 32'd0);

    for (int i = 0; i <= readyDelay; i++) begin
      @(posedge clk); #1;
      busIf.req_ready = (i == readyDelay);
      busIf.rsp_valid = strayRsp && (i == 0);
      busIf.rsp_rdata = 32'hCAFE_BABE;
      busIf.rsp_error = strayRsp && (i == 0);
      @(negedge clk);
      checkOutput("reqValid", 32'(busIf.req_valid), 32'd1);
      checkOutput("reqAddr", busIf.addr, busAddr);
      checkOutput("reqWe", 32'(busIf.we), 32'(strb != 4'b0000));
      checkOutput("reqStrb", 32'(busIf.wstrb), 32'(strb));
      checkOutput("reqWdata", busIf.wdata, wdata);
      checkOutput("reqStall", 32'(coreIf.stall), 32'd1);
    end

    for (int k = 0; k <= lastWait; k++) begin
      @(posedge clk); #1;
      busIf.req_ready = 1'b0;
      busIf.rsp_valid = (k == rspDelay);
      busIf.rsp_rdata = rspData;
      busIf.rsp_error = rspErr && (k == rspDelay);
      @(negedge clk);
      checkOutput("waitStall", 32'(coreIf.stall), 32'd1);
      checkOutput("waitValid", 32'(busIf.req_valid), 32'd0);
    end

    @(posedge clk); #1;
    busIf.rsp_valid = 1'b0;
    busIf.rsp_error = 1'b0;
    @(negedge clk);
    e = expQ.pop_front();
    checkOutput("doneStall", 32'(coreIf.stall), 32'd0);
    checkOutput("doneErr", 32'(err), 32'(e.err));
    checkOutput("doneRdata", coreIf.read_data, e.rdata);
    checkOutput("doneErrAddr", errAddr, e.errAddr);
    if (!holdReq) begin
      coreIf.req = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("idleErrPulse", 32'(err), 32'd0);
      checkOutput("idleNoStall", 32'(coreIf.stall), 32'd0);
      checkOutput("idleRdataHold", coreIf.read_data, e.rdata);
    end
  endtask

  // Abandons an access in WAIT_RSP with reset, then sends a late response.
  task automatic resetMidAccess();
    @(posedge clk); #1;
    coreIf.req          = 1'b1;
    coreIf.address      = 32'h0000_9000;
    coreIf.write_enable = 4'b0000;
    @(posedge clk); #1;
    busIf.req_ready = 1'b1;
    @(posedge clk); #1;
    busIf.req_ready = 1'b0;
    @(negedge clk);
    checkOutput("preResetStall", 32'(coreIf.stall), 32'd1);
    #2;
    reset      = 1'b1;
    coreIf.req = 1'b0;
    #1;
    checkOutput("rstStall", 32'(coreIf.stall), 32'd0);
    checkOutput("rstValid", 32'(busIf.req_valid), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    checkOutput("rstErrAddr", errAddr, 32'd0);
    checkOutput("rstRdata", coreIf.read_data, 32'd0);
    modelRdata   = 32'd0;
    modelErrAddr = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    busIf.rsp_valid = 1'b1;
    busIf.rsp_rdata = 32'h7777_7777;
    busIf.rsp_error = 1'b1;
    @(negedge clk);
    checkOutput("lateRspStall", 32'(coreIf.stall), 32'd0);
    @(posedge clk); #1;
    busIf.rsp_valid = 1'b0;
    busIf.rsp_error = 1'b0;
    @(negedge clk);
    checkOutput("lateRspRdata", coreIf.read_data, 32'd0);
    checkOutput("lateRspErr", 32'(err), 32'd0);
    checkOutput("lateRspValid", 32'(busIf.req_valid), 32'd0);
    checkOutput("lateRspStall2", 32'(coreIf.stall), 32'd0);
  endtask

  // Main sequence.
  initial begin
    checkCount          = 0;
    errorCount          = 0;
    modelRdata          = 32'd0;
    modelErrAddr        = 32'd0;
    reset               = 1'b1;
    coreIf.req          = 1'b0;
    coreIf.address      = 32'd0;
    coreIf.write_data   = 32'd0;
    coreIf.write_enable = 4'b0000;
    busIf.req_ready     = 1'b0;
    busIf.rsp_valid     = 1'b0;
    busIf.rsp_rdata     = 32'd0;
    busIf.rsp_error     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetStall", 32'(coreIf.stall), 32'd0);
    checkOutput("resetValid", 32'(busIf.req_valid), 32'd0);
    checkOutput("resetErr", 32'(err), 32'd0);
    checkOutput("resetErrAddr", errAddr, 32'd0);
    checkOutput("resetRdata", coreIf.read_data, 32'd0);
    reset = 1'b0;

    applyStimulus(32'h0000_1006, 32'h0, 4'b0000, 0, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000_2000, 32'hAABB_CCDD, 4'b1100, 5, 1, 32'h9999_9999, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000_3008, 32'h0, 4'b0000, 0, -1, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000_4003, 32'h0, 4'b0000, 2, 2, 32'h55AA_1234, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0000_6004, 32'h0102_0304, 4'b0011, 1, 0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0000_500C, 32'h0, 4'b0000, 0, TbTimeout - 1, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0000_7000, 32'h0, 4'b0000, 0, 0, 32'h0102_0304, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0000_7104, 32'h0, 4'b0000, 0, 1, 32'h0A0B_0C0D, 1'b0, 1'b0, 1'b0);
    resetMidAccess();
    applyStimulus(32'h0000_8000, 32'h0, 4'b0000, 1, 0, 32'h89AB_CDEF, 1'b0, 1'b0, 1'b0);

    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
